// File: rtl/bforge_apb_master_bridge.sv
// bforge_apb_master_bridge: valid/ready request channel to APB4 master transfers,
// with a bounded ACCESS-phase timeout so a hung slave cannot stall the requester.
module bforge_apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    psel_q, penable_q, pwrite_q, rsp_valid_q, rsp_slverr_q, rsp_timeout_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q, rsp_rdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;
  assign req_ready   = state_q == IDLE;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          state_q  <= SETUP;
          psel_q   <= 1'b1;
          paddr_q  <= req_addr;
          pwrite_q <= req_write;
          pwdata_q <= req_write ? req_wdata : '0;
          pstrb_q  <= req_write ? req_strb : '0;
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        ACCESS: begin
          // pready wins over a timeout expiring in the same cycle
          if (pready || (TIMEOUT_CYCLES != 0 && cnt_q == LAST)) begin
            state_q       <= RESP;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= (pready && !pwrite_q) ? prdata : '0;
            rsp_slverr_q  <= pready ? pslverr : 1'b1;
            rsp_timeout_q <= !pready;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bforge_apb_master_bridge.sv
// tb_bforge_apb_master_bridge: directed transfers checked every cycle against a
// timeline model (accept edge, ACCESS length, handshake edge) plus literal expectations.
module tb_bforge_apb_master_bridge;
  localparam int TO = 4;
  logic        pclk = 0, presetn = 0;
  logic        req_valid = 0, req_ready, req_write = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_strb = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = 0;
  logic        pready = 0, pslverr = 0;
  int          checks = 0, errors = 0, cyc = 0;

  bforge_apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transfer is described by its accept edge a, completion edge d and
  // handshake edge h; outputs after edge n follow from where n falls between them.
  bit          busy = 0;
  int          a = 0, d = -1, h = -1;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic [3:0]  m_strb = 0;
  logic        m_write = 0, m_err = 0, m_to = 0;
  always @(negedge pclk) begin
    int n;
    bit e_rv;
    n = cyc;
    if (!presetn) begin
      busy = 0; m_addr = 0; m_wdata = 0; m_strb = 0; m_write = 0;
      m_rdata = 0; m_err = 0; m_to = 0;
    end
    if (busy && h >= 0 && n >= h) busy = 0;
    e_rv = busy && d >= 0 && n >= d;
    chk("psel", psel, busy && (d < 0 || n < d));
    chk("penable", penable, busy && n > a && (d < 0 || n < d));
    chk("rsp_valid", rsp_valid, e_rv);
    chk("req_ready", req_ready, !busy);
    chk("paddr", paddr, m_addr);
    chk("pwrite", pwrite, m_write);
    chk("pwdata", pwdata, m_wdata);
    chk("pstrb", pstrb, m_strb);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("rsp_slverr", rsp_slverr, m_err);
    chk("rsp_timeout", rsp_timeout, m_to);
    if (presetn) begin
      if (!busy && req_valid) begin
        busy = 1; a = n + 1; d = -1; h = -1;
        m_addr = req_addr; m_write = req_write;
        m_wdata = req_write ? req_wdata : 0;
        m_strb = req_write ? req_strb : 0;
      end else if (busy && d < 0 && n > a) begin
        if (pready) begin
          d = n + 1; m_rdata = m_write ? 0 : prdata; m_err = pslverr; m_to = 0;
        end else if (n - a == TO) begin
          d = n + 1; m_rdata = 0; m_err = 1; m_to = 1;
        end
      end else if (e_rv && h < 0 && rsp_ready) begin
        h = n + 1;
      end
    end
  end

  // waits<0: pready never rises. rcyc counts the accept cycle as 0.
  task automatic xfer(input logic [31:0] ad, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, input int waits, input logic ew, input logic ed,
                      input logic [31:0] rd, input int hold, input bit keep,
                      output int aw, output int rcyc, output int alen);
    bit ok;
    logic [31:0] snap;
    req_valid = 1; req_addr = ad; req_write = wr; req_wdata = wd; req_strb = st;
    rsp_ready = (hold == 0); prdata = rd; pready = 0; pslverr = ew;
    ok = 0; aw = 0; rcyc = 0; alen = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = req_ready;
      @(posedge pclk); #1;
      aw++;
    end
    chk("accepted", ok, 1);
    if (!keep) req_valid = 0;
    for (int c = 1; c <= 40 && rcyc == 0; c++) begin
      @(posedge pclk); #1;
      if (penable) alen++;
      if (rsp_valid) rcyc = c + 1;
      else begin
        pready = waits >= 0 && c == waits + 1;
        pslverr = pready ? ed : ew;
      end
    end
    chk("rsp_seen", rcyc != 0, 1);
    pready = 0; pslverr = 0;
    snap = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge pclk); #1;
      chk("hold_rdata", rsp_rdata, snap);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_psel", psel, 0);
    end
    rsp_ready = 1;
    @(posedge pclk); #1;
    rsp_ready = 0;
    chk("req_ready_back", req_ready, 1);
    chk("rsp_valid_drop", rsp_valid, 0);
  endtask

  initial begin
    int aw, rc, al;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    presetn = 1;
    @(posedge pclk); #1;
    // zero-wait write
    xfer(32'h10, 1, 32'hA5A5_0001, 4'hF, 0, 0, 0, 32'h0, 0, 0, aw, rc, al);
    chk("t1_rcyc", rc, 3); chk("t1_alen", al, 1);
    chk("t1_rdata", rsp_rdata, 0); chk("t1_slverr", rsp_slverr, 0);
    chk("t1_pwdata", pwdata, 32'hA5A5_0001); chk("t1_paddr", paddr, 32'h10);
    // read with 3 wait states; pready lands on the last allowed cycle
    xfer(32'h20, 0, 32'hFFFF_FFFF, 4'hF, 3, 0, 0, 32'hDEAD_BEEF, 0, 0, aw, rc, al);
    chk("t2_alen", al, 4); chk("t2_rcyc", rc, 6);
    chk("t2_rdata", rsp_rdata, 32'hDEAD_BEEF); chk("t2_pstrb", pstrb, 0);
    chk("t2_pwdata", pwdata, 0); chk("t2_timeout", rsp_timeout, 0);
    // slave error with pready, then error only during wait states
    xfer(32'h30, 1, 32'h1234_5678, 4'h3, 0, 1, 1, 32'h0, 0, 0, aw, rc, al);
    chk("t3_slverr", rsp_slverr, 1); chk("t3_timeout", rsp_timeout, 0);
    xfer(32'h34, 1, 32'h1234_5678, 4'h3, 2, 1, 0, 32'h0, 0, 0, aw, rc, al);
    chk("t3b_slverr", rsp_slverr, 0); chk("t3b_alen", al, 3);
    // timeout on a read
    xfer(32'h44, 0, 32'h0, 4'h0, -1, 0, 0, 32'h1234_5678, 0, 0, aw, rc, al);
    chk("t4_alen", al, 4); chk("t4_rcyc", rc, 6);
    chk("t4_slverr", rsp_slverr, 1); chk("t4_timeout", rsp_timeout, 1);
    chk("t4_rdata", rsp_rdata, 0);
    xfer(32'h48, 1, 32'hCAFE_0000, 4'hC, 3, 0, 0, 32'h0, 0, 0, aw, rc, al);
    chk("t4b_timeout", rsp_timeout, 0); chk("t4b_slverr", rsp_slverr, 0);
    chk("t4b_alen", al, 4);
    // response backpressure with a request already waiting
    xfer(32'h50, 0, 32'h0, 4'h0, 1, 0, 0, 32'h0BAD_F00D, 5, 1, aw, rc, al);
    chk("t5_rdata", rsp_rdata, 32'h0BAD_F00D);
    xfer(32'h54, 1, 32'h0000_00FF, 4'h1, 0, 0, 0, 32'h0, 0, 0, aw, rc, al);
    chk("t5_next_accept", aw, 1); chk("t5_pstrb", pstrb, 4'h1);
    // asynchronous reset during ACCESS
    req_valid = 1; req_addr = 32'h60; req_write = 0; prdata = 32'h55; pready = 0;
    @(posedge pclk); #1;
    req_valid = 0;
    @(posedge pclk); #1;
    chk("t6_in_access", penable, 1);
    #2 presetn = 0;
    #1;
    chk("t6_psel", psel, 0); chk("t6_penable", penable, 0);
    chk("t6_rsp_valid", rsp_valid, 0); chk("t6_req_ready", req_ready, 1);
    @(posedge pclk); #1;
    presetn = 1; pready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      chk("t6_no_stale", rsp_valid, 0);
      chk("t6_idle", req_ready, 1);
    end
    pready = 0;
    xfer(32'h70, 0, 32'h0, 4'h0, 0, 0, 0, 32'h7777_0001, 0, 0, aw, rc, al);
    chk("t6_after_rdata", rsp_rdata, 32'h7777_0001); chk("t6_after_rcyc", rc, 3);
    repeat (3) @(posedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
